// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

  localparam int LED_W = 4;

  typedef enum logic [1:0] {
    FLOW_L   = 2'd0,
    FLOW_R   = 2'd1,
    PINGPONG = 2'd2,
    BLINK    = 2'd3
  } mode_t;

  localparam logic [LED_W-1:0] PAT_FLOW_L   = 4'b0001;
  localparam logic [LED_W-1:0] PAT_FLOW_R   = 4'b1000;
  localparam logic [LED_W-1:0] PAT_PINGPONG = 4'b0001;
  localparam logic [LED_W-1:0] PAT_BLINK    = 4'b1111;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      FLOW_L:   next_mode = FLOW_R;
      FLOW_R:   next_mode = PINGPONG;
      PINGPONG: next_mode = BLINK;
      default:  next_mode = FLOW_L;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] start_pattern(input mode_t m);
    case (m)
      FLOW_L:   start_pattern = PAT_FLOW_L;
      FLOW_R:   start_pattern = PAT_FLOW_R;
      PINGPONG: start_pattern = PAT_PINGPONG;
      default:  start_pattern = PAT_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF sync, stable-level debounce, one-cycle pulse on accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_sync;

  assign w_sync = r_sync[1];
  assign press  = r_press;

  // r_cnt counts consecutive synced samples that differ from the accepted level;
  // any sample equal to it restarts the run.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_press <= 1'b0;
      if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
        r_press  <= ~w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED bank pattern controller: tick generator, mode FSM and pattern register driven by two keys.
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int TICK_CYCLES     = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             key_mode_n,
  input  logic             key_speed_n,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             tick
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] PM1_0 = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PM1_1 = CNT_W'((TICK_CYCLES >> 1) - 1);
  localparam logic [CNT_W-1:0] PM1_2 = CNT_W'((TICK_CYCLES >> 2) - 1);
  localparam logic [CNT_W-1:0] PM1_3 = CNT_W'((TICK_CYCLES >> 3) - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             w_mode_ev;
  logic             w_speed_ev;
  logic             w_tick;
  logic [CNT_W-1:0] w_pm1;

  mode_t            r_mode,   w_mode_nxt;
  logic [LED_W-1:0] r_led,    w_led_nxt;
  logic             r_dir_up, w_dir_nxt;
  logic [1:0]       r_speed,  w_speed_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .sys_clk (sys_clk),
    .rst_n   (w_rst_n),
    .key_n   (key_mode_n),
    .press   (w_mode_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_db (
    .sys_clk (sys_clk),
    .rst_n   (w_rst_n),
    .key_n   (key_speed_n),
    .press   (w_speed_ev)
  );

  always_comb begin
    case (r_speed)
      2'd0:    w_pm1 = PM1_0;
      2'd1:    w_pm1 = PM1_1;
      2'd2:    w_pm1 = PM1_2;
      default: w_pm1 = PM1_3;
    endcase
  end

  assign w_tick = (r_cnt == w_pm1);

  always_comb begin
    w_mode_nxt  = r_mode;
    w_led_nxt   = r_led;
    w_dir_nxt   = r_dir_up;
    w_speed_nxt = r_speed;
    w_cnt_nxt   = r_cnt + 1'b1;
    if (w_tick || w_mode_ev || w_speed_ev) w_cnt_nxt = '0;
    if (w_speed_ev) w_speed_nxt = r_speed + 2'd1;
    // A mode change overrides any step due on the same cycle.
    if (w_mode_ev) begin
      w_mode_nxt = next_mode(r_mode);
      w_led_nxt  = start_pattern(w_mode_nxt);
      w_dir_nxt  = 1'b1;
    end else if (w_tick) begin
      case (r_mode)
        FLOW_L: w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
        FLOW_R: w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
        PINGPONG: begin
          if (r_dir_up) begin
            w_led_nxt = r_led << 1;
            if (r_led[LED_W-2]) w_dir_nxt = 1'b0;
          end else begin
            w_led_nxt = r_led >> 1;
            if (r_led[1]) w_dir_nxt = 1'b1;
          end
        end
        default: w_led_nxt = ~r_led;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mode   <= FLOW_L;
      r_led    <= PAT_FLOW_L;
      r_dir_up <= 1'b1;
      r_speed  <= 2'd0;
      r_cnt    <= '0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_led    <= w_led_nxt;
      r_dir_up <= w_dir_nxt;
      r_speed  <= w_speed_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign led   = r_led;
  assign mode  = r_mode;
  assign speed = r_speed;
  assign tick  = w_tick;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with TICK_CYCLES=16, DEBOUNCE_CYCLES=4.
module tb_led_mode_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       key_mode_n;
  logic       key_speed_n;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  led_mode_sequencer #(.TICK_CYCLES(16), .DEBOUNCE_CYCLES(4)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .key_mode_n  (key_mode_n),
    .key_speed_n (key_speed_n),
    .led         (led),
    .mode        (mode),
    .speed       (speed),
    .tick        (tick)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Hold a key low; the debounced pulse appears 6 cycles after the fall and is applied on the 7th edge.
  task automatic press(input bit sel, input int hold);
    if (sel) key_speed_n = 1'b0;
    else     key_mode_n  = 1'b0;
    step(6);
    chk("press_pulse", sel ? dut.u_speed_db.press : dut.u_mode_db.press, 8'd1);
    step(1);
    if (hold > 7) step(hold - 7);
    if (sel) key_speed_n = 1'b1;
    else     key_mode_n  = 1'b1;
  endtask

  logic [3:0] exp_led;
  logic [3:0] pp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    rst_n = 1'b0; key_mode_n = 1'b1; key_speed_n = 1'b1;
    step(3);
    chk("rst_led", led, 8'h1);
    chk("rst_mode", mode, 8'd0);
    chk("rst_speed", speed, 8'd0);
    chk("rst_tick", tick, 8'd0);
    rst_n = 1'b1;
    step(2);

    // free-running FLOW_L at period 16
    exp_led = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(14); chk("pre_tick", tick, 8'd0);
      step(1);  chk("tick", tick, 8'd1); chk("led_hold", led, exp_led);
      exp_led = {exp_led[2:0], exp_led[3]};
      step(1);  chk("flow_l", led, exp_led); chk("tick_low", tick, 8'd0);
    end

    // 3-cycle glitches must not register
    for (int i = 0; i < 2; i++) begin
      key_mode_n = 1'b0; step(3);
      key_mode_n = 1'b1; step(3);
    end
    chk("glitch_mode", mode, 8'd0);
    step(3); chk("glitch_tick", tick, 8'd1); chk("glitch_led", led, 8'h1);
    step(1); chk("glitch_step", led, 8'h2); chk("glitch_mode2", mode, 8'd0);

    // mode press, held 10 cycles
    press(1'b0, 10);
    chk("m1_mode", mode, 8'd1); chk("m1_led", led, 8'h8);
    step(12); chk("m1_tick", tick, 8'd1); chk("m1_hold", led, 8'h8);
    step(1);  chk("m1_step", led, 8'h4);

    // PINGPONG
    press(1'b0, 7);
    chk("m2_mode", mode, 8'd2); chk("m2_led", led, 8'h1);
    step(15); chk("m2_tick", tick, 8'd1);
    step(1);  chk("pp0", led, {4'h0, pp[0]});
    for (int i = 1; i < 7; i++) begin
      step(16); chk("pp", led, {4'h0, pp[i]});
    end

    // BLINK
    press(1'b0, 7);
    chk("m3_mode", mode, 8'd3); chk("m3_led", led, 8'hF);
    step(16); chk("blink0", led, 8'h0);
    step(16); chk("blink1", led, 8'hF);
    step(16); chk("blink2", led, 8'h0);

    // speed 1: period 8
    press(1'b1, 7);
    chk("s1_speed", speed, 8'd1); chk("s1_hold", led, 8'h0);
    step(7); chk("s1_tick", tick, 8'd1);
    step(1); chk("s1_step", led, 8'hF); chk("s1_tlow", tick, 8'd0);
    // speed 2: period 4
    press(1'b1, 7);
    chk("s2_speed", speed, 8'd2); chk("s2_hold", led, 8'hF);
    step(3); chk("s2_tick", tick, 8'd1);
    step(1); chk("s2_step", led, 8'h0);
    step(4); chk("s2_step2", led, 8'hF);
    // speed 3: period 2
    press(1'b1, 7);
    chk("s3_speed", speed, 8'd3); chk("s3_hold", led, 8'h0);
    step(1); chk("s3_tick", tick, 8'd1);
    step(1); chk("s3_step", led, 8'hF);
    step(4); chk("s3_step2", led, 8'hF);
    // wrap to speed 0: period 16
    press(1'b1, 7);
    chk("s0_speed", speed, 8'd0); chk("s0_hold", led, 8'h0);
    step(15); chk("s0_tick", tick, 8'd1);
    step(1);  chk("s0_step", led, 8'hF);

    // mode event on the tick cycle: entry pattern wins
    step(9);
    key_mode_n = 1'b0;
    step(6); chk("coin_tick", tick, 8'd1); chk("coin_pulse", dut.u_mode_db.press, 8'd1);
    step(1); key_mode_n = 1'b1;
    chk("coin_mode", mode, 8'd0); chk("coin_led", led, 8'h1); chk("coin_tlow", tick, 8'd0);
    step(15); chk("coin_tick2", tick, 8'd1);
    step(1);  chk("coin_step", led, 8'h2);

    // speed event on the tick cycle: step still applied
    step(9);
    key_speed_n = 1'b0;
    step(6); chk("spd_coin_tick", tick, 8'd1);
    step(1); key_speed_n = 1'b1;
    chk("spd_coin_speed", speed, 8'd1); chk("spd_coin_led", led, 8'h4);
    step(8); chk("spd_coin_step", led, 8'h8);

    // simultaneous mode and speed events
    key_mode_n = 1'b0; key_speed_n = 1'b0;
    step(7);
    key_mode_n = 1'b1; key_speed_n = 1'b1;
    chk("both_mode", mode, 8'd1); chk("both_speed", speed, 8'd2); chk("both_led", led, 8'h8);
    step(3); chk("both_tick", tick, 8'd1);
    step(1); chk("both_step", led, 8'h4);

    // into BLINK, then reset mid-run
    step(2);
    press(1'b0, 7);
    chk("r_m2", mode, 8'd2); chk("r_m2_led", led, 8'h1);
    step(6);
    press(1'b0, 7);
    chk("r_m3", mode, 8'd3); chk("r_m3_led", led, 8'hF);
    step(2); chk("r_m3_hold", led, 8'hF);
    key_mode_n = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", led, 8'h1); chk("arst_mode", mode, 8'd0);
    chk("arst_speed", speed, 8'd0); chk("arst_tick", tick, 8'd0);
    key_mode_n = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(2);
    step(15); chk("post_tick", tick, 8'd1); chk("post_led", led, 8'h1);
    step(1);  chk("post_step", led, 8'h2); chk("post_mode", mode, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
